ysyx_22040750_serial_div: RTL and testbench

- Multicycle radix-2 restoring divider. It is the responder end of the EX-stage ALU's divide handshake.
- The ALU drives sign/zero-extended 64-bit operands, a signedness flag and a start pulse. This block returns quotient and remainder with a one-cycle valid pulse.
- It sits inside the EX stage beside the serial Booth multiplier. The ALU caches results if EX_MEM is stalled, so this block has no output backpressure.

---
 rtl/ysyx_22040750_div_pkg.sv | 16 +
 rtl/ysyx_22040750_div_step.sv | 23 ++
 rtl/ysyx_22040750_serial_div.sv | 126 ++++++++++++
 tb/tb_ysyx_22040750_serial_div.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040750_div_pkg.sv
// Shared widths, FSM states and special-case result constants for the serial divider.
package ysyx_22040750_div_pkg;

  localparam int XLEN  = 64;
  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] DIV_ZERO_Q = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN    = {1'b1, {(XLEN-1){1'b0}}};

endpackage

// File: rtl/ysyx_22040750_div_step.sv
// One restoring-division iteration: shift {r, a} left, subtract |b| when it fits.
// Purely combinational; the quotient bit enters the vacated LSB of a.
module ysyx_22040750_div_step
  import ysyx_22040750_div_pkg::*;
(
  input  logic [2*XLEN-1:0] ra_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] ra_o,
  output logic              qbit_o
);

  // 65 bits: a remainder below |b| can reach 2|b|-1 after the shift.
  logic [XLEN:0]   r_sh;
  logic [XLEN-1:0] r_new;

  always_comb begin
    r_sh   = ra_i[2*XLEN-1:XLEN-1];
    qbit_o = (r_sh >= {1'b0, b_i});
    r_new  = qbit_o ? (r_sh[XLEN-1:0] - b_i) : r_sh[XLEN-1:0];
    ra_o   = {r_new, ra_i[XLEN-2:0], qbit_o};
  end

endmodule

// File: rtl/ysyx_22040750_serial_div.sv
// Radix-2 restoring divider for the EX-stage ALU; 64 CALC cycles, special cases finish in one.
// Optional macro YSYX_22040750_DIV_EARLY_EXIT_EN short-cuts |a| < |b| straight to DONE.
module ysyx_22040750_serial_div
  import ysyx_22040750_div_pkg::*;
(
  input  logic            I_sys_clk,
  input  logic            I_rst,
  input  logic [XLEN-1:0] I_dividend,
  input  logic [XLEN-1:0] I_divisor,
  input  logic            I_is_signed,
  input  logic            I_div_valid,
  output logic            O_busy,
  output logic [XLEN-1:0] O_quotient,
  output logic [XLEN-1:0] O_remainder,
  output logic            O_Q_valid
);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] ra_q;
  logic [XLEN-1:0]   b_q;
  logic              sq_q, sr_q;
  logic              busy_q, valid_q;
  logic [XLEN-1:0]   quot_q, rem_q;

  logic [XLEN-1:0]   abs_a_d, abs_b_d;
  logic              sq_d, sr_d, div_zero_d, ovf_d;
  logic [2*XLEN-1:0] step_ra;
  logic              step_q;
  logic [XLEN-1:0]   q_fin, r_fin;

  always_comb begin
    sq_d       = I_is_signed & (I_dividend[XLEN-1] ^ I_divisor[XLEN-1]);
    sr_d       = I_is_signed & I_dividend[XLEN-1];
    abs_a_d    = (I_is_signed & I_dividend[XLEN-1]) ? -I_dividend : I_dividend;
    abs_b_d    = (I_is_signed & I_divisor[XLEN-1])  ? -I_divisor  : I_divisor;
    div_zero_d = (I_divisor == '0);
    ovf_d      = I_is_signed & (I_dividend == INT_MIN) & (I_divisor == DIV_ZERO_Q);
  end

  ysyx_22040750_div_step u_step (
    .ra_i   (ra_q),
    .b_i    (b_q),
    .ra_o   (step_ra),
    .qbit_o (step_q)
  );

  // Result of the final iteration, taken straight from the step so DONE lands at T+65.
  assign q_fin = {step_ra[XLEN-1:1], step_q};
  assign r_fin = step_ra[2*XLEN-1:XLEN];

  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ra_q    <= '0;
      b_q     <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (I_div_valid) begin
            sq_q   <= sq_d;
            sr_q   <= sr_d;
            b_q    <= abs_b_d;
            ra_q   <= {{XLEN{1'b0}}, abs_a_d};
            busy_q <= 1'b1;
            if (div_zero_d) begin
              quot_q  <= DIV_ZERO_Q;
              rem_q   <= I_dividend;
              valid_q <= 1'b1;
              state_q <= DONE;
            end else if (ovf_d) begin
              quot_q  <= I_dividend;
              rem_q   <= '0;
              valid_q <= 1'b1;
              state_q <= DONE;
`ifdef YSYX_22040750_DIV_EARLY_EXIT_EN
            end else if (abs_a_d < abs_b_d) begin
              // q = 0 and sign-corrected |a| is the raw dividend itself.
              quot_q  <= '0;
              rem_q   <= I_dividend;
              valid_q <= 1'b1;
              state_q <= DONE;
`endif
            end else begin
              cnt_q   <= CNT_W'(XLEN - 1);
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          ra_q  <= step_ra;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            quot_q  <= sq_q ? -q_fin : q_fin;
            rem_q   <= sr_q ? -r_fin : r_fin;
            valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign O_busy      = busy_q;
  assign O_Q_valid   = valid_q;
  assign O_quotient  = quot_q;
  assign O_remainder = rem_q;

endmodule

// File: tb/tb_ysyx_22040750_serial_div.sv
// Directed plus random bench for the serial divider, checked against arithmetic reference.
module tb_ysyx_22040750_serial_div;

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] IMIN = 64'h8000_0000_0000_0000;

  logic        I_sys_clk = 1'b0;
  logic        I_rst = 1'b1;
  logic [63:0] I_dividend = '0;
  logic [63:0] I_divisor = '0;
  logic        I_is_signed = 1'b0;
  logic        I_div_valid = 1'b0;
  logic        O_busy;
  logic [63:0] O_quotient;
  logic [63:0] O_remainder;
  logic        O_Q_valid;

  int n_vec = 0;
  int n_err = 0;

  ysyx_22040750_serial_div dut (
    .I_sys_clk   (I_sys_clk),
    .I_rst       (I_rst),
    .I_dividend  (I_dividend),
    .I_divisor   (I_divisor),
    .I_is_signed (I_is_signed),
    .I_div_valid (I_div_valid),
    .O_busy      (O_busy),
    .O_quotient  (O_quotient),
    .O_remainder (O_remainder),
    .O_Q_valid   (O_Q_valid)
  );

  always #5 I_sys_clk = ~I_sys_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RISC-V division semantics expressed with native arithmetic.
  task automatic ref_div(input logic [63:0] a, input logic [63:0] b, input logic s,
                         output logic [63:0] q, output logic [63:0] r);
    logic signed [63:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 64'd0) begin
      q = ALL1;
      r = a;
    end else if (s && a == IMIN && b == ALL1) begin
      q = a;
      r = 64'd0;
    end else if (s) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  function automatic int exp_lat(input logic [63:0] a, input logic [63:0] b, input logic s);
    logic [63:0] ua, ub;
    ua = (s && a[63]) ? -a : a;
    ub = (s && b[63]) ? -b : b;
    if (b == 64'd0) return 1;
    if (s && a == IMIN && b == ALL1) return 1;
`ifdef YSYX_22040750_DIV_EARLY_EXIT_EN
    if (ua < ub) return 1;
`endif
    if (ua == ub && ua == 64'd0) return 65;
    return 65;
  endfunction

  // Called #1 after a posedge while the DUT is idle; returns in the pulse cycle.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                       output int lat, output logic [63:0] q, output logic [63:0] r);
    I_dividend  = a;
    I_divisor   = b;
    I_is_signed = s;
    I_div_valid = 1'b1;
    @(posedge I_sys_clk); #1;
    I_div_valid = 1'b0;
    lat = 1;
    while (!O_Q_valid && lat < 200) begin
      @(posedge I_sys_clk); #1;
      lat++;
    end
    q = O_quotient;
    r = O_remainder;
  endtask

  task automatic check_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic s);
    int lat;
    logic [63:0] q, r, eq, er;
    do_op(a, b, s, lat, q, r);
    ref_div(a, b, s, eq, er);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat(a, b, s)));
    chk({tag, "_q"}, q, eq);
    chk({tag, "_r"}, r, er);
    // Step out of DONE so the next request lands in IDLE (T+66).
    @(posedge I_sys_clk); #1;
  endtask

  initial begin
    int lat, pulses, pcyc, busy_bad;
    logic [63:0] q, r, a, b;
    logic s;

    // Reset state
    repeat (3) @(posedge I_sys_clk);
    #1;
    I_rst = 1'b0;
    chk("rst_busy", 64'(O_busy), 64'd0);
    chk("rst_valid", 64'(O_Q_valid), 64'd0);
    chk("rst_q", O_quotient, 64'd0);
    chk("rst_r", O_remainder, 64'd0);

    // Unsigned 100/7 with busy tracked every cycle T+1..T+65
    I_dividend = 64'd100; I_divisor = 64'd7; I_is_signed = 1'b0; I_div_valid = 1'b1;
    @(posedge I_sys_clk); #1;
    I_div_valid = 1'b0;
    pulses = 0; pcyc = 0; busy_bad = 0;
    for (int c = 1; c <= 66; c++) begin
      if (c <= 65 && !O_busy) busy_bad++;
      if (c == 66 && O_busy) busy_bad++;
      if (O_Q_valid) begin
        pulses++;
        pcyc = c;
        q = O_quotient;
        r = O_remainder;
      end
      if (c < 66) begin
        @(posedge I_sys_clk); #1;
      end
    end
    chk("u100_7_busy", 64'(busy_bad), 64'd0);
    chk("u100_7_pulses", 64'(pulses), 64'd1);
    chk("u100_7_lat", 64'(pcyc), 64'd65);
    chk("u100_7_q", q, 64'd14);
    chk("u100_7_r", r, 64'd2);
    chk("hold_q", O_quotient, 64'd14);

    // Signed cases
    check_op("s_m7_2", -64'sd7, 64'd2, 1'b1);
    chk("s_m7_2_q_const", O_quotient, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("s_m7_2_r_const", O_remainder, ALL1);
    check_op("s_7_m2", 64'd7, -64'sd2, 1'b1);
    chk("s_7_m2_q_const", O_quotient, -64'sd3);
    chk("s_7_m2_r_const", O_remainder, 64'd1);

    // Divide by zero, overflow, and overflow operands unsigned
    check_op("dz_s", 64'd5, 64'd0, 1'b1);
    check_op("dz_u", 64'd5, 64'd0, 1'b0);
    chk("dz_u_q_const", O_quotient, ALL1);
    check_op("ovf_s", IMIN, ALL1, 1'b1);
    chk("ovf_s_q_const", O_quotient, IMIN);
    check_op("ovf_u", IMIN, ALL1, 1'b0);
    chk("ovf_u_r_const", O_remainder, IMIN);
    check_op("small_a", 64'd3, 64'd1000, 1'b0);
    check_op("neg_small_a", -64'sd3, 64'd1000, 1'b1);
    check_op("word_min", 64'hFFFF_FFFF_8000_0000, ALL1, 1'b1);

    // Second request while busy must be ignored
    I_dividend = 64'd1000; I_divisor = 64'd10; I_is_signed = 1'b0; I_div_valid = 1'b1;
    @(posedge I_sys_clk); #1;
    pulses = 0; pcyc = 0;
    for (int c = 1; c <= 75; c++) begin
      I_div_valid = (c == 10);
      if (O_Q_valid) begin
        pulses++;
        pcyc = c;
        q = O_quotient;
      end
      @(posedge I_sys_clk); #1;
    end
    I_div_valid = 1'b0;
    chk("ign_pulses", 64'(pulses), 64'd1);
    chk("ign_lat", 64'(pcyc), 64'd65);
    chk("ign_q", q, 64'd100);

    // Reset mid-operation
    I_dividend = 64'd123456789; I_divisor = 64'd1000; I_is_signed = 1'b0; I_div_valid = 1'b1;
    @(posedge I_sys_clk); #1;
    I_div_valid = 1'b0;
    repeat (19) begin
      @(posedge I_sys_clk); #1;
    end
    I_rst = 1'b1;
    @(posedge I_sys_clk); #1;
    I_rst = 1'b0;
    chk("mrst_busy", 64'(O_busy), 64'd0);
    chk("mrst_q", O_quotient, 64'd0);
    chk("mrst_r", O_remainder, 64'd0);
    pulses = 0;
    for (int c = 0; c < 70; c++) begin
      if (O_Q_valid) pulses++;
      @(posedge I_sys_clk); #1;
    end
    chk("mrst_nopulse", 64'(pulses), 64'd0);
    check_op("after_rst_9_3", 64'd9, 64'd3, 1'b0);
    chk("after_rst_q_const", O_quotient, 64'd3);

    // Back-to-back random traffic
    for (int i = 0; i < 400; i++) begin
      a = {$urandom, $urandom};
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0: b = 64'd0;
        1: begin a = IMIN; b = ALL1; end
        2, 3, 4: begin
          b = 64'($urandom_range(1, 1000));
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        default: b = {$urandom, $urandom} >> $urandom_range(0, 63);
      endcase
      check_op("rnd", a, b, s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
